minirisc_fetch: RTL

MINIRISC_FETCH -- requirements
Module: minirisc_fetch

---
 rtl/minirisc_fetch.sv | 115 +++++++++++
 1 files changed

// File: rtl/minirisc_fetch.sv
// Instruction fetch front-end for the minirisc core: stores a small program and
// streams {opcode, operand} entries to the core over a valid/ready handshake.
module minirisc_fetch #(
  parameter int          DEPTH   = 16,
  parameter logic [7:0]  HALT_OP = 8'hFF,
  localparam int         PW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_opcode,
  input  logic [7:0]    wr_operand,
  input  logic          clear,
  input  logic          start,
  input  logic          jump_en,
  input  logic [PW-1:0] jump_addr,
  input  logic          instr_ready,
  output logic          instr_valid,
  output logic [7:0]    instr_opcode,
  output logic [7:0]    instr_operand,
  output logic [PW-1:0] pc,
  output logic [PW:0]   prog_len,
  output logic          full,
  output logic [1:0]    state_out,
  output logic          halted
);

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] operand;
  } instr_t;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  state_t          state, state_nxt;
  instr_t          mem [DEPTH];
  instr_t          rd_ent;
  logic [PW:0]     target;
  logic [PW-1:0]   rd_addr;
  logic            hs, halt_now, go, can_wr, is_full, do_clear;

  // Target is one bit wider than pc so pc+1 past the last entry never wraps.
  always_comb begin
    target   = jump_en ? {1'b0, jump_addr} : ({1'b0, pc} + {{PW{1'b0}}, 1'b1});
    hs       = (state == RUN) && instr_valid && instr_ready;
    halt_now = (instr_opcode == HALT_OP) || (target >= prog_len);
    is_full  = (prog_len == (PW+1)'(DEPTH));
    do_clear = clear && ((state == IDLE) || (state == HALT));
    go       = start && !clear && (prog_len != '0) &&
               ((state == IDLE) || (state == HALT));
    can_wr   = (state == IDLE) && wr_en && !clear && !is_full;
    rd_addr  = go ? '0 : target[PW-1:0];
    rd_ent   = mem[rd_addr];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = RUN;
      RUN:     if (hs && halt_now) state_nxt = HALT;
      HALT:    if (clear) state_nxt = IDLE;
               else if (go) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    state_out = state;
    halted    = (state == HALT);
    full      = is_full;
  end

  // Program memory: not reset, so a reset or clear only forgets the length.
  always_ff @(posedge clk) begin
    if (!rst && can_wr) mem[prog_len[PW-1:0]] <= {wr_opcode, wr_operand};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= '0;
      prog_len      <= '0;
      instr_valid   <= 1'b0;
      instr_opcode  <= '0;
      instr_operand <= '0;
    end else begin
      if (do_clear)    prog_len <= '0;
      else if (can_wr) prog_len <= prog_len + 1'b1;

      if (go) begin
        pc            <= '0;
        instr_valid   <= 1'b1;
        instr_opcode  <= rd_ent.opcode;
        instr_operand <= rd_ent.operand;
      end else if (hs) begin
        // Accepted entry is replaced in the same edge, so no bubble on valid.
        if (halt_now) begin
          instr_valid <= 1'b0;
        end else begin
          pc            <= target[PW-1:0];
          instr_opcode  <= rd_ent.opcode;
          instr_operand <= rd_ent.operand;
        end
      end
    end
  end

endmodule
